vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator for the elevator display path. Generates pixel coordinates for the pixel generator and produces hsync/vsync/data-enable delayed by a configurable pipeline depth, so they stay aligned with the RGB output of a pixel generator that has non-zero latency. It also blanks RGB outside the active area and emits frame/line start strobes for the simulation-state update logic.

---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_delay_line.sv | 28 ++
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA types: default 640x480@60 timing, the 12-bit RGB struct and
// the colour-bar palette used by the optional test pattern.
package vga_pkg;

   localparam int H_ACTIVE_DEF   = 640;
   localparam int H_FP_DEF       = 16;
   localparam int H_SYNC_DEF     = 96;
   localparam int H_BP_DEF       = 48;
   localparam int V_ACTIVE_DEF   = 480;
   localparam int V_FP_DEF       = 10;
   localparam int V_SYNC_DEF     = 2;
   localparam int V_BP_DEF       = 33;
   localparam int PIPE_DELAY_DEF = 2;
   localparam int CW_DEF         = 10;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   localparam rgb12_t BAR_WHITE   = 12'hFFF;
   localparam rgb12_t BAR_YELLOW  = 12'hFF0;
   localparam rgb12_t BAR_CYAN    = 12'h0FF;
   localparam rgb12_t BAR_GREEN   = 12'h0F0;
   localparam rgb12_t BAR_MAGENTA = 12'hF0F;
   localparam rgb12_t BAR_RED     = 12'hF00;
   localparam rgb12_t BAR_BLUE    = 12'h00F;
   localparam rgb12_t BAR_BLACK   = 12'h000;

   // Bars run left to right in the classic order, index 0 at x = 0.
   function automatic rgb12_t bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a parametrised reset value (DEPTH >= 1).
module vga_delay_line
   import vga_pkg::*;
#(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             pixel_clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with sync/de/rgb aligned to a PIPE_DELAY-latency
// pixel generator. Define VGA_TEST_PATTERN_EN to add pattern_sel and colour bars.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int H_FP       = H_FP_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BP       = H_BP_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int V_FP       = V_FP_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BP       = V_BP_DEF,
   parameter bit HSYNC_POL  = 1'b0,
   parameter bit VSYNC_POL  = 1'b0,
   parameter int PIPE_DELAY = PIPE_DELAY_DEF,
   parameter int CW         = CW_DEF
) (
   input  logic          pixel_clk,
   input  logic          reset,
   input  logic          run,
   output logic [CW-1:0] x_coord,
   output logic [CW-1:0] y_coord,
   output logic          active,
   output logic          frame_start,
   output logic          line_start,
   input  logic [11:0]   rgb_in,
`ifdef VGA_TEST_PATTERN_EN
   input  logic          pattern_sel,
`endif
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [11:0]   rgb_out
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [2:0]    SYNC_IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

   if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_delay
      $fatal(1, "vga_timing_gen: PIPE_DELAY must be in 1..8");
   end
   if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_totals
      $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed 2**CW");
   end

   logic        counting;
   logic [31:0] x_ext;
   logic [31:0] y_ext;
   logic        h_in_sync;
   logic        v_in_sync;
   logic [2:0]  sync_p0;
   logic [2:0]  sync_pd;
   rgb12_t      src;

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         x_coord <= '0;
         y_coord <= '0;
      end else if (!run) begin
         x_coord <= '0;
         y_coord <= '0;
      end else if (x_coord == H_LAST) begin
         x_coord <= '0;
         y_coord <= (y_coord == V_LAST) ? '0 : y_coord + 1'b1;
      end else begin
         x_coord <= x_coord + 1'b1;
      end
   end

   // Raw timing from the undelayed counters; everything idles while not running.
   assign counting    = run & ~reset;
   assign x_ext       = 32'(x_coord);
   assign y_ext       = 32'(y_coord);
   assign h_in_sync   = counting && (x_ext >= HS_START) && (x_ext < HS_END);
   assign v_in_sync   = counting && (y_ext >= VS_START) && (y_ext < VS_END);
   assign active      = counting && (x_ext < H_ACTIVE) && (y_ext < V_ACTIVE);
   assign frame_start = counting && (x_coord == '0) && (y_coord == '0);
   assign line_start  = counting && (x_coord == '0);
   assign sync_p0     = {h_in_sync ? HSYNC_POL : ~HSYNC_POL,
                         v_in_sync ? VSYNC_POL : ~VSYNC_POL,
                         active};

   // The first PIPE_DELAY-1 stages live here; the output register is the last.
   if (PIPE_DELAY > 1) begin : g_sync_dl
      vga_delay_line #(.WIDTH(3), .DEPTH(PIPE_DELAY - 1), .RESET_VAL(SYNC_IDLE)) u_sync_dl (
         .pixel_clk (pixel_clk),
         .reset     (reset),
         .din       (sync_p0),
         .dout      (sync_pd)
      );
   end else begin : g_sync_bypass
      assign sync_pd = sync_p0;
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   logic [CW-1:0] x_pd;
   logic [31:0]   bar_idx;

   if (PIPE_DELAY > 1) begin : g_x_dl
      vga_delay_line #(.WIDTH(CW), .DEPTH(PIPE_DELAY - 1), .RESET_VAL('0)) u_x_dl (
         .pixel_clk (pixel_clk),
         .reset     (reset),
         .din       (x_coord),
         .dout      (x_pd)
      );
   end else begin : g_x_bypass
      assign x_pd = x_coord;
   end

   assign bar_idx = 32'(x_pd) / BAR_W;
   assign src     = pattern_sel ? bar_colour((bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0])
                                : rgb12_t'(rgb_in);
`else
   assign src = rgb12_t'(rgb_in);
`endif

   // Output stage: sync, de and blanked rgb all update on the same edge.
   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         hsync   <= ~HSYNC_POL;
         vsync   <= ~VSYNC_POL;
         de      <= 1'b0;
         rgb_out <= '0;
      end else begin
         hsync   <= sync_pd[2];
         vsync   <= sync_pd[1];
         de      <= sync_pd[0];
         rgb_out <= sync_pd[0] ? src : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: two small-raster instances (delay 2 and delay 5 / active-high
// hsync) plus one default 640x480 instance, all sharing clock, reset and run.
module tb_vga_timing_gen;

   logic        pixel_clk = 1'b0;
   logic        reset     = 1'b1;
   logic        run       = 1'b0;
   logic [11:0] rgb_in    = 12'hFFF;
`ifdef VGA_TEST_PATTERN_EN
   logic        pattern_sel = 1'b0;
`endif

   int compared   = 0;
   int mismatched = 0;
   int n          = 0;

   logic [5:0]  x_a, y_a, x_b, y_b;
   logic [9:0]  x_c, y_c;
   logic        act_a, fs_a, ls_a, hs_a, vs_a, de_a;
   logic        act_b, fs_b, ls_b, hs_b, vs_b, de_b;
   logic        act_c, fs_c, ls_c, hs_c, vs_c, de_c;
   logic [11:0] rgb_a, rgb_b, rgb_c;

   always #5 pixel_clk = ~pixel_clk;

   // Small raster: H_TOTAL 24 (sync 18..21), V_TOTAL 10 (sync lines 7..8).
   vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_ACTIVE(6), .V_FP(1),
      .V_SYNC(2), .V_BP(1), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DELAY(2), .CW(6)) dut_a (
      .pixel_clk(pixel_clk), .reset(reset), .run(run), .x_coord(x_a), .y_coord(y_a),
      .active(act_a), .frame_start(fs_a), .line_start(ls_a), .rgb_in(rgb_in),
`ifdef VGA_TEST_PATTERN_EN
      .pattern_sel(pattern_sel),
`endif
      .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb_out(rgb_a));

   vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_ACTIVE(6), .V_FP(1),
      .V_SYNC(2), .V_BP(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .PIPE_DELAY(5), .CW(6)) dut_b (
      .pixel_clk(pixel_clk), .reset(reset), .run(run), .x_coord(x_b), .y_coord(y_b),
      .active(act_b), .frame_start(fs_b), .line_start(ls_b), .rgb_in(rgb_in),
`ifdef VGA_TEST_PATTERN_EN
      .pattern_sel(pattern_sel),
`endif
      .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb_out(rgb_b));

   vga_timing_gen dut_c (
      .pixel_clk(pixel_clk), .reset(reset), .run(run), .x_coord(x_c), .y_coord(y_c),
      .active(act_c), .frame_start(fs_c), .line_start(ls_c), .rgb_in(rgb_in),
`ifdef VGA_TEST_PATTERN_EN
      .pattern_sel(pattern_sel),
`endif
      .hsync(hs_c), .vsync(vs_c), .de(de_c), .rgb_out(rgb_c));

   task automatic tick();
      @(posedge pixel_clk);
      #1;
      n++;
   endtask

   // Drain all pipelines with run low, then raise run: cycle 0 is x=0,y=0.
   task automatic start_run();
      run = 1'b0;
      repeat (8) tick();
      run = 1'b1;
      #1;
      n = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      run   = 1'b0;
      repeat (3) tick();
      run = 1'b1;
      #1;
      compared++; if (x_a !== 6'd0) begin mismatched++; $display("FAIL reset_x_a: got %0d want 0", x_a); end
      compared++; if (y_a !== 6'd0) begin mismatched++; $display("FAIL reset_y_a: got %0d want 0", y_a); end
      compared++; if (hs_a !== 1'b1) begin mismatched++; $display("FAIL reset_hs_a: got %b want 1", hs_a); end
      compared++; if (vs_a !== 1'b1) begin mismatched++; $display("FAIL reset_vs_a: got %b want 1", vs_a); end
      compared++; if (de_a !== 1'b0) begin mismatched++; $display("FAIL reset_de_a: got %b want 0", de_a); end
      compared++; if (rgb_a !== 12'h000) begin mismatched++; $display("FAIL reset_rgb_a: got %h want 000", rgb_a); end
      compared++; if (hs_b !== 1'b0) begin mismatched++; $display("FAIL reset_hs_b: got %b want 0", hs_b); end
      compared++; if (fs_a !== 1'b0) begin mismatched++; $display("FAIL reset_fs_a: got %b want 0", fs_a); end
      compared++; if (ls_c !== 1'b0) begin mismatched++; $display("FAIL reset_ls_c: got %b want 0", ls_c); end
      compared++; if (hs_c !== 1'b1) begin mismatched++; $display("FAIL reset_hs_c: got %b want 1", hs_c); end
      run   = 1'b0;
      reset = 1'b0;
      repeat (2) tick();
      compared++; if (x_c !== 10'd0) begin mismatched++; $display("FAIL idle_x_c: got %0d want 0", x_c); end
   endtask

   task automatic test_hsync();
      int   fa = -1, ra = -1, fa2 = -1, rb = -1, fb = -1, fc = -1, rc = -1, fc2 = -1, low_a = 0;
      logic pa, pb, pc;
      start_run();
      pa = hs_a; pb = hs_b; pc = hs_c;
      for (int i = 0; i < 1500; i++) begin
         tick();
         if (pa === 1'b1 && hs_a === 1'b0) begin if (fa < 0) fa = n; else if (fa2 < 0) fa2 = n; end
         if (pa === 1'b0 && hs_a === 1'b1 && ra < 0) ra = n;
         if (n < 48 && hs_a === 1'b0) low_a++;
         if (pb === 1'b0 && hs_b === 1'b1 && rb < 0) rb = n;
         if (pb === 1'b1 && hs_b === 1'b0 && fb < 0) fb = n;
         if (pc === 1'b1 && hs_c === 1'b0) begin if (fc < 0) fc = n; else if (fc2 < 0) fc2 = n; end
         if (pc === 1'b0 && hs_c === 1'b1 && rc < 0) rc = n;
         pa = hs_a; pb = hs_b; pc = hs_c;
      end
      compared++; if (fa !== 20) begin mismatched++; $display("FAIL hs_a_fall: got %0d want 20", fa); end
      compared++; if (ra !== 24) begin mismatched++; $display("FAIL hs_a_rise: got %0d want 24", ra); end
      compared++; if (fa2 !== 44) begin mismatched++; $display("FAIL hs_a_period: got %0d want 44", fa2); end
      compared++; if (low_a !== 8) begin mismatched++; $display("FAIL hs_a_low_count: got %0d want 8", low_a); end
      compared++; if (rb !== 23) begin mismatched++; $display("FAIL hs_b_rise: got %0d want 23", rb); end
      compared++; if (fb !== 27) begin mismatched++; $display("FAIL hs_b_fall: got %0d want 27", fb); end
      compared++; if (fc !== 658) begin mismatched++; $display("FAIL hs_c_fall: got %0d want 658", fc); end
      compared++; if (rc !== 754) begin mismatched++; $display("FAIL hs_c_rise: got %0d want 754", rc); end
      compared++; if (fc2 !== 1458) begin mismatched++; $display("FAIL hs_c_period: got %0d want 1458", fc2); end
   endtask

   task automatic test_vsync_frame();
      int   fs_a_cnt = 0, ls_a_cnt = 0, fs_c_cnt = 0, ls_c_cnt = 0, bad_xy = 0;
      int   vf = -1, vr = -1, vf2 = -1;
      logic pv;
      start_run();
      for (int i = 0; i < 480; i++) begin
         if (fs_a === 1'b1) fs_a_cnt++;
         if (ls_a === 1'b1) ls_a_cnt++;
         if (fs_c === 1'b1) fs_c_cnt++;
         if (ls_c === 1'b1) ls_c_cnt++;
         if (x_a !== 6'(n % 24) || y_a !== 6'((n / 24) % 10)) bad_xy++;
         if (x_b !== 6'(n % 24) || y_b !== 6'((n / 24) % 10)) bad_xy++;
         pv = vs_a;
         tick();
         if (pv === 1'b1 && vs_a === 1'b0) begin if (vf < 0) vf = n; else if (vf2 < 0) vf2 = n; end
         if (pv === 1'b0 && vs_a === 1'b1 && vr < 0) vr = n;
      end
      compared++; if (vf !== 170) begin mismatched++; $display("FAIL vs_a_fall: got %0d want 170", vf); end
      compared++; if (vr !== 218) begin mismatched++; $display("FAIL vs_a_rise: got %0d want 218", vr); end
      compared++; if (vf2 !== 410) begin mismatched++; $display("FAIL vs_a_period: got %0d want 410", vf2); end
      compared++; if (fs_a_cnt !== 2) begin mismatched++; $display("FAIL fs_a_count: got %0d want 2", fs_a_cnt); end
      compared++; if (ls_a_cnt !== 20) begin mismatched++; $display("FAIL ls_a_count: got %0d want 20", ls_a_cnt); end
      compared++; if (fs_c_cnt !== 1) begin mismatched++; $display("FAIL fs_c_count: got %0d want 1", fs_c_cnt); end
      compared++; if (ls_c_cnt !== 1) begin mismatched++; $display("FAIL ls_c_count: got %0d want 1", ls_c_cnt); end
      compared++; if (bad_xy !== 0) begin mismatched++; $display("FAIL xy_sequence: got %0d bad cycles want 0", bad_xy); end
   endtask

   task automatic test_de();
      int de_cnt = 0, line_cnt = 0, first_a = -1, first_b = -1, bad_rgb = 0;
      rgb_in = 12'hFFF;
      start_run();
      for (int i = 0; i < 242; i++) begin
         if (de_a === 1'b1) begin de_cnt++; if (first_a < 0) first_a = n; end
         if (de_a === 1'b1 && n >= 2 && n <= 25) line_cnt++;
         if (de_b === 1'b1 && first_b < 0) first_b = n;
         if (rgb_a !== (de_a ? 12'hFFF : 12'h000)) bad_rgb++;
         if (rgb_b !== (de_b ? 12'hFFF : 12'h000)) bad_rgb++;
         if (rgb_c !== (de_c ? 12'hFFF : 12'h000)) bad_rgb++;
         tick();
      end
      compared++; if (de_cnt !== 96) begin mismatched++; $display("FAIL de_a_frame_count: got %0d want 96", de_cnt); end
      compared++; if (line_cnt !== 16) begin mismatched++; $display("FAIL de_a_line_count: got %0d want 16", line_cnt); end
      compared++; if (first_a !== 2) begin mismatched++; $display("FAIL de_a_first: got %0d want 2", first_a); end
      compared++; if (first_b !== 5) begin mismatched++; $display("FAIL de_b_first: got %0d want 5", first_b); end
      compared++; if (bad_rgb !== 0) begin mismatched++; $display("FAIL rgb_blanking: got %0d bad cycles want 0", bad_rgb); end
   endtask

   task automatic test_run_drop();
      start_run();
      repeat (82) tick();
      compared++; if (x_a !== 6'd10 || y_a !== 6'd3) begin mismatched++; $display("FAIL drop_pos: got %0d,%0d want 10,3", x_a, y_a); end
      run = 1'b0;
      #1;
      compared++; if (act_a !== 1'b0) begin mismatched++; $display("FAIL drop_active: got %b want 0", act_a); end
      tick();
      compared++; if (x_a !== 6'd0 || y_a !== 6'd0) begin mismatched++; $display("FAIL drop_origin: got %0d,%0d want 0,0", x_a, y_a); end
      compared++; if (x_c !== 10'd0) begin mismatched++; $display("FAIL drop_x_c: got %0d want 0", x_c); end
      compared++; if (fs_a !== 1'b0) begin mismatched++; $display("FAIL drop_fs: got %b want 0", fs_a); end
      compared++; if (de_a !== 1'b1) begin mismatched++; $display("FAIL drop_de_a_tail: got %b want 1", de_a); end
      tick();
      compared++; if (de_a !== 1'b0) begin mismatched++; $display("FAIL drop_de_a_drain: got %b want 0", de_a); end
      compared++; if (rgb_a !== 12'h000) begin mismatched++; $display("FAIL drop_rgb_a: got %h want 000", rgb_a); end
      repeat (3) tick();
      compared++; if (de_b !== 1'b0) begin mismatched++; $display("FAIL drop_de_b_drain: got %b want 0", de_b); end
      compared++; if (hs_b !== 1'b0) begin mismatched++; $display("FAIL drop_hs_b_idle: got %b want 0", hs_b); end
      compared++; if (x_a !== 6'd0) begin mismatched++; $display("FAIL drop_hold: got %0d want 0", x_a); end
      run = 1'b1;
      #1;
      compared++; if (fs_a !== 1'b1) begin mismatched++; $display("FAIL rerun_fs: got %b want 1", fs_a); end
      compared++; if (ls_a !== 1'b1) begin mismatched++; $display("FAIL rerun_ls: got %b want 1", ls_a); end
      compared++; if (act_a !== 1'b1) begin mismatched++; $display("FAIL rerun_active: got %b want 1", act_a); end
      tick();
      compared++; if (x_a !== 6'd1 || fs_a !== 1'b0) begin mismatched++; $display("FAIL rerun_step: got x=%0d fs=%b want x=1 fs=0", x_a, fs_a); end
   endtask

   task automatic test_reset_mid();
      start_run();
      repeat (700) tick();
      compared++; if (x_c !== 10'd700) begin mismatched++; $display("FAIL mid_x_c: got %0d want 700", x_c); end
      compared++; if (hs_c !== 1'b0) begin mismatched++; $display("FAIL mid_hs_c: got %b want 0", hs_c); end
      reset = 1'b1;
      #1;
      compared++; if (x_c !== 10'd0 || y_c !== 10'd0) begin mismatched++; $display("FAIL mid_rst_xy: got %0d,%0d want 0,0", x_c, y_c); end
      compared++; if (hs_c !== 1'b1) begin mismatched++; $display("FAIL mid_rst_hs_c: got %b want 1", hs_c); end
      compared++; if (vs_c !== 1'b1 || de_c !== 1'b0) begin mismatched++; $display("FAIL mid_rst_vs_de: got %b,%b want 1,0", vs_c, de_c); end
      compared++; if (hs_b !== 1'b0) begin mismatched++; $display("FAIL mid_rst_hs_b: got %b want 0", hs_b); end
      compared++; if (fs_c !== 1'b0) begin mismatched++; $display("FAIL mid_rst_fs: got %b want 0", fs_c); end
      repeat (2) tick();
      compared++; if (x_a !== 6'd0 || rgb_c !== 12'h000) begin mismatched++; $display("FAIL mid_rst_hold: got x=%0d rgb=%h want 0,000", x_a, rgb_c); end
      run   = 1'b0;
      reset = 1'b0;
      tick();
   endtask

`ifdef VGA_TEST_PATTERN_EN
   task automatic test_pattern();
      int bad_white = 0, bad_yellow = 0, bad_black = 0;
      pattern_sel = 1'b1;
      rgb_in      = 12'h123;
      start_run();
      for (int i = 0; i < 646; i++) begin
         if (n >= 2 && n <= 81 && rgb_c !== 12'hFFF) bad_white++;
         if (n >= 82 && n <= 161 && rgb_c !== 12'hFF0) bad_yellow++;
         if ((n < 2 || n >= 562) && rgb_c !== 12'h000) bad_black++;
         if (n == 302) begin
            compared++; if (rgb_c !== 12'h0F0) begin mismatched++; $display("FAIL bar_green: got %h want 0F0", rgb_c); end
         end
         tick();
      end
      compared++; if (bad_white !== 0) begin mismatched++; $display("FAIL bar_white: got %0d bad want 0", bad_white); end
      compared++; if (bad_yellow !== 0) begin mismatched++; $display("FAIL bar_yellow: got %0d bad want 0", bad_yellow); end
      compared++; if (bad_black !== 0) begin mismatched++; $display("FAIL bar_black_blank: got %0d bad want 0", bad_black); end
      pattern_sel = 1'b0;
      rgb_in      = 12'hFFF;
   endtask
`endif

   initial begin
      test_reset();
      test_hsync();
      test_vsync_frame();
      test_de();
      test_run_drop();
      test_reset_mid();
`ifdef VGA_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
